// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bundle for the fetch stage
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, instruction register, next-PC select
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    fetch_unit_if.master    imem,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            halt,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [XLEN-1:0] Instr,
    output logic            instr_valid,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic            func7_5,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] NOP_WORD  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] JALR_MASK = ~XLEN'(1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Reserved PCSrc code falls through to sequential flow.
    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01:   next_pc = PCTarget;
            2'b10:   next_pc = ALUResult & JALR_MASK;
            default: next_pc = pc_plus4;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        case (state_q)
            S_FETCH: begin
                if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!halt) begin
                    pc_d = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // Request is masked while reset is held so a restart never overlaps a stale fetch.
    assign imem.imem_req  = (state_q == S_FETCH) && !reset;
    assign imem.imem_addr = pc_q;

    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign Instr       = instr_q;
    assign instr_valid = (state_q == S_EXEC);
    assign op          = instr_q[6:0];
    assign func3       = instr_q[14:12];
    assign func7_5     = instr_q[30];
    assign fetch_fault = fault_q;

endmodule
